// File: rtl/struct_pipe_pkg.sv
// struct_pipe_pkg: shared defaults and helpers for the struct_pipe elastic pipeline.
// The parity helper is only referenced when STRUCT_PIPE_PARITY_EN is defined.
package struct_pipe_pkg;

  localparam int STRUCT_PIPE_DEF_WIDTH = 8;
  localparam int STRUCT_PIPE_DEF_DEPTH = 2;

  // Widest payload the parity helper covers; narrower payloads are zero-extended.
  localparam int PARITY_MAX_W = 256;

  // Even parity (XOR reduction) of a zero-extended payload.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/struct_pipe_stage.sv
// struct_pipe_stage: one register slot of the elastic pipeline.
// Holds a valid bit and an opaque payload; loads when its advance signal is high,
// and drops its valid bit on a synchronous flush.
module struct_pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          adv_i,
  input  logic          vld_i,
  input  logic [PW-1:0] payload_i,
  output logic          vld_o,
  output logic [PW-1:0] payload_o
);

  logic          vld_q;
  logic [PW-1:0] payload_q;

  // Valid bit: cleared by flush, otherwise follows the upstream slot when advancing.
  // NOTE: sequential state uses non-blocking assignments so every slot samples the
  // pre-edge value of its neighbour, which is what makes the chain shift and not ripple.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (adv_i) begin
      vld_q <= vld_i;
    end
  end

  // Payload: loads on advance, holds otherwise; flush leaves it alone since it is
  // meaningless once the valid bit is gone.
  // NOTE: the payload is reset as well, so an empty slot never presents X downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      payload_q <= '0;
    end else if (adv_i) begin
      payload_q <= payload_i;
    end
  end

  assign vld_o     = vld_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/struct_pipe.sv
// struct_pipe: DEPTH-stage elastic register pipeline with valid/ready handshake,
// back-pressure, synchronous flush and a registered occupancy count.
// Optional build macro STRUCT_PIPE_PARITY_EN adds a parity bit per stage and out_perr.
module struct_pipe
  import struct_pipe_pkg::*;
#(
  parameter int WIDTH = STRUCT_PIPE_DEF_WIDTH,
  parameter int DEPTH = STRUCT_PIPE_DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef STRUCT_PIPE_PARITY_EN
  ,
  output logic                       out_perr
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
`ifdef STRUCT_PIPE_PARITY_EN
    logic             parity;
`endif
    logic [WIDTH-1:0] data;
  } payload_t;

  typedef struct packed {
    logic     vld;
    payload_t pl;
  } stage_t;

  stage_t           stage_q [DEPTH];
  logic [DEPTH-1:0] vld_vec;
  logic [DEPTH-1:0] adv;
  payload_t         head_pl;
  logic             in_accept;
  logic             out_fire;
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    occ_d;

  // Ready chain: a slot may advance if the slot after it advances or it is empty.
  // NOTE: every combinational output gets a default before any conditional logic,
  // so no path leaves a bit unassigned and no latch is inferred.
  always_comb begin
    logic chain;
    adv          = '0;
    chain        = out_ready | ~vld_vec[DEPTH-1];
    adv[DEPTH-1] = chain;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      chain  = chain | ~vld_vec[k];
      adv[k] = chain;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign in_accept = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Payload presented to stage 0, with parity computed at entry when enabled.
  always_comb begin
    head_pl      = '0;
    head_pl.data = in_data;
`ifdef STRUCT_PIPE_PARITY_EN
    head_pl.parity = calc_parity(PARITY_MAX_W'(in_data));
`endif
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic     vld_in;
    payload_t pl_in;

    if (k == 0) begin : g_head
      assign vld_in = in_accept;
      assign pl_in  = head_pl;
    end else begin : g_body
      assign vld_in = stage_q[k-1].vld;
      assign pl_in  = stage_q[k-1].pl;
    end

    struct_pipe_stage #(
      .PW($bits(payload_t))
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush_i   (flush),
      .adv_i     (adv[k]),
      .vld_i     (vld_in),
      .payload_i (pl_in),
      .vld_o     (stage_q[k].vld),
      .payload_o (stage_q[k].pl)
    );

    assign vld_vec[k] = stage_q[k].vld;
  end

  // Occupancy next state: valid words are conserved through the shift, so the count
  // only moves by one accepted word in and one delivered word out; flush empties all.
  always_comb begin
    occ_d = occ_q + CW'(in_accept) - CW'(out_fire);
    if (flush) begin
      occ_d = '0;
    end
  end

  // Occupancy register, updated on the same edge as the stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid = stage_q[DEPTH-1].vld;
  assign out_data  = stage_q[DEPTH-1].pl.data;
  assign occupancy = occ_q;

`ifdef STRUCT_PIPE_PARITY_EN
  assign out_perr = out_valid & (^out_data ^ stage_q[DEPTH-1].pl.parity);
`endif

endmodule

// File: tb/tb_struct_pipe.sv
// tb_struct_pipe: directed bench for struct_pipe at DEPTH 1, 2 and 4 sharing one
// stimulus stream; each instance is checked against hand-derived expectations.
module tb_struct_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       rdy1, ov1;
  logic [7:0] od1;
  logic [0:0] occ1;
  logic       rdy2, ov2;
  logic [7:0] od2;
  logic [1:0] occ2;
  logic       rdy4, ov4;
  logic [7:0] od4;
  logic [2:0] occ4;
`ifdef STRUCT_PIPE_PARITY_EN
  logic       perr1, perr2, perr4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  struct_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1)
`ifdef STRUCT_PIPE_PARITY_EN
    , .out_perr(perr1)
`endif
  );

  struct_pipe #(.WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .occupancy(occ2)
`ifdef STRUCT_PIPE_PARITY_EN
    , .out_perr(perr2)
`endif
  );

  struct_pipe #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .occupancy(occ4)
`ifdef STRUCT_PIPE_PARITY_EN
    , .out_perr(perr4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Compare one instance's registered outputs; data only matters while valid.
  task automatic check_dut(input string tag, input int d, input logic exp_v,
                           input logic [7:0] exp_d, input int exp_occ);
    logic       v;
    logic [7:0] dat;
    int         occ;
    case (d)
      1:       begin v = ov1; dat = od1; occ = int'(occ1); end
      2:       begin v = ov2; dat = od2; occ = int'(occ2); end
      default: begin v = ov4; dat = od4; occ = int'(occ4); end
    endcase
    check($sformatf("%s d%0d out_valid", tag, d), 32'(v), 32'(exp_v));
    if (exp_v) check($sformatf("%s d%0d out_data", tag, d), 32'(dat), 32'(exp_d));
    check($sformatf("%s d%0d occupancy", tag, d), 32'(occ), 32'(exp_occ));
  endtask

  initial begin
    int depths [3] = '{1, 2, 4};

    // ---- reset state ----
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    #2;
    foreach (depths[i]) check_dut("in_reset", depths[i], 1'b0, 8'h00, 0);
    check("in_reset d2 out_data", 32'(od2), 32'h0);
    do_reset();
    check("post_reset d1 in_ready", 32'(rdy1), 32'h1);
    check("post_reset d2 in_ready", 32'(rdy2), 32'h1);
    check("post_reset d4 in_ready", 32'(rdy4), 32'h1);
    check("post_reset d2 out_data", 32'(od2), 32'h0);

    // ---- stream 0x11,0x22,0x33 with out_ready=1 ----
    // Word w leaves on edge d+w+1, so after edge n it is on the output when n-d == w.
    out_ready = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      in_valid = (n <= 3);
      in_data  = 8'(8'h11 * n);
      #1;
      check($sformatf("stream n%0d d1 in_ready", n), 32'(rdy1), 32'h1);
      check($sformatf("stream n%0d d2 in_ready", n), 32'(rdy2), 32'h1);
      check($sformatf("stream n%0d d4 in_ready", n), 32'(rdy4), 32'h1);
      tick();
      foreach (depths[i]) begin
        int d, w, acc, fired;
        d     = depths[i];
        w     = n - d;
        acc   = (n < 3) ? n : 3;
        fired = (w < 0) ? 0 : ((w > 3) ? 3 : w);
        check_dut($sformatf("stream n%0d", n), d, (w >= 0 && w < 3),
                  8'(8'h11 * (w + 1)), acc - fired);
      end
    end

    // ---- back-pressure: push 0xA0,0xA1 with out_ready=0 ----
    do_reset();
    in_valid = 1'b1; in_data = 8'hA0; tick();
    in_data = 8'hA1; tick();
    in_valid = 1'b0; in_data = 8'h5A;
    tick(); tick();
    #1;
    check("bp d1 in_ready", 32'(rdy1), 32'h0);
    check("bp d2 in_ready", 32'(rdy2), 32'h0);
    check("bp d4 in_ready", 32'(rdy4), 32'h1);
    check_dut("bp_hold", 1, 1'b1, 8'hA0, 1);
    check_dut("bp_hold", 2, 1'b1, 8'hA0, 2);
    check_dut("bp_hold", 4, 1'b1, 8'hA0, 2);
    out_ready = 1'b1;
    #1;
    check_dut("bp_release", 2, 1'b1, 8'hA0, 2);
    tick();
    check_dut("bp_drain1", 1, 1'b0, 8'h00, 0);
    check_dut("bp_drain1", 2, 1'b1, 8'hA1, 1);
    check_dut("bp_drain1", 4, 1'b1, 8'hA1, 1);
    tick();
    foreach (depths[i]) check_dut("bp_drain2", depths[i], 1'b0, 8'h00, 0);

    // ---- full pipeline, continuous streaming (DEPTH=2) ----
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hB0 + i);
      #1;
      check($sformatf("full i%0d d2 in_ready", i), 32'(rdy2), 32'h1);
      tick();
      check_dut($sformatf("full i%0d", i), 2, (i >= 1), 8'(8'hB0 + i - 1), (i == 0) ? 1 : 2);
    end
    in_valid = 1'b0;
    tick();
    check_dut("full_tail1", 2, 1'b1, 8'hB9, 1);
    tick();
    check_dut("full_tail2", 2, 1'b0, 8'h00, 0);

    // ---- flush while full with in_valid held high (DEPTH=2) ----
    do_reset();
    in_valid = 1'b1; in_data = 8'hC0; tick();
    in_data = 8'hC1; tick();
    check_dut("flush_pre", 2, 1'b1, 8'hC0, 2);
    flush = 1'b1; in_data = 8'hC2;
    #1;
    check("flush d2 in_ready", 32'(rdy2), 32'h0);
    check("flush d4 in_ready", 32'(rdy4), 32'h0);
    tick();
    check_dut("flush_post", 2, 1'b0, 8'h00, 0);
    check_dut("flush_post", 4, 1'b0, 8'h00, 0);
    flush = 1'b0; in_data = 8'hC3; out_ready = 1'b1;
    #1;
    check("after_flush d2 in_ready", 32'(rdy2), 32'h1);
    tick();
    in_valid = 1'b0;
    check_dut("after_flush1", 2, 1'b0, 8'h00, 1);
    tick();
    check_dut("after_flush2", 2, 1'b1, 8'hC3, 1);
    tick();
    check_dut("after_flush3", 2, 1'b0, 8'h00, 0);

    // ---- asynchronous reset between edges ----
    do_reset();
    in_valid = 1'b1; in_data = 8'hD0; tick();
    in_data = 8'hD1; tick();
    in_valid = 1'b0;
    check_dut("async_pre", 2, 1'b1, 8'hD0, 2);
    #3;
    reset = 1'b1;
    #1;
    check("async d2 out_data", 32'(od2), 32'h0);
    foreach (depths[i]) check_dut("async_rst", depths[i], 1'b0, 8'h00, 0);
    reset = 1'b0;
    #1;
    check("async_release d2 in_ready", 32'(rdy2), 32'h1);

`ifdef STRUCT_PIPE_PARITY_EN
    // ---- parity: clean word, then a corrupted data bit in the output stage ----
    do_reset();
    in_valid = 1'b1; in_data = 8'h07; tick();
    in_valid = 1'b0; tick();
    check_dut("parity_clean", 2, 1'b1, 8'h07, 1);
    check("parity_clean d2 out_perr", 32'(perr2), 32'h0);
    force dut2.g_stage[1].u_stage.payload_q = 9'h106;
    #1;
    check("parity_flip d2 out_data", 32'(od2), 32'h06);
    check("parity_flip d2 out_perr", 32'(perr2), 32'h1);
    release dut2.g_stage[1].u_stage.payload_q;
    do_reset();
    check("parity_reset d2 out_perr", 32'(perr2), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/struct_pipe.md
Name: struct_pipe

Overview:
Parametrised elastic register pipeline. Each stage is held as a packed struct {vld, data}. It generalises a fixed two-register in→out path to DEPTH stages of WIDTH bits, with a valid/ready handshake, back-pressure, a synchronous flush and an occupancy count. It sits between producer and consumer blocks wherever registered, stallable transport is needed.

Parameters:
WIDTH, 8, payload width in bits (>=1)
DEPTH, 2, number of register stages (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all stages
in_valid  input  1  producer has data
in_ready  output  1  pipeline accepts in_data this cycle
in_data  input  WIDTH  payload in
out_valid  output  1  stage DEPTH-1 holds data
out_ready  input  1  consumer accepts out_data
out_data  output  WIDTH  payload out
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset is decided as reset, asynchronous, active-high; clock is clk.
- Reset: every stage struct clears to {vld=0, data=0}. Consequences: out_valid=0, out_data=0, occupancy=0, in_ready=1 once reset deasserts.
- Stages are indexed 0 (input) to DEPTH-1 (output). out_valid = stage[DEPTH-1].vld. out_data = stage[DEPTH-1].data.
- Advance rule:
  - adv[DEPTH-1] = out_ready | ~stage[DEPTH-1].vld.
  - adv[k] = adv[k+1] | ~stage[k].vld. This is a combinational ready chain with no bubbles required.
  - in_ready = adv[0] & ~flush.
- On a clock edge:
  - If adv[k], stage[k] loads stage[k-1]; stage 0 loads {in_valid & in_ready, in_data}.
  - Otherwise stage[k] holds.
  - Data of an invalid stage is don't-care, but it must still be registered (no X from reset onward).
- Latency: DEPTH cycles from accepted input to out_valid with no stall. Throughput is 1 word/cycle while out_ready=1.
- Full (all vld=1) with out_ready=0: in_ready=0 and all stages hold. Full with out_ready=1: in_ready=1 and the pipeline shifts.
- flush=1: on the next edge every vld clears, regardless of out_ready.
  - in_ready=0 that cycle, so any in_valid is not accepted (producer must hold).
  - A word on out_valid & out_ready during the flush cycle counts as transferred.
- Occupancy: registered count of vld bits, updated on the same edge as the stages. Range 0..DEPTH; it never wraps.
- Reset asserted mid-transfer: all state clears immediately (asynchronous). In-flight words are lost.
- DEPTH=1: single stage, in_ready = out_ready | ~out_valid.
- Input stability: out_valid/out_data must stay stable while out_valid & ~out_ready. Data is never duplicated or dropped except by flush or reset.

Optional Feature:
- Macro: STRUCT_PIPE_PARITY_EN.
- When defined:
  - Stage struct gains a parity field, computed as even parity (XOR) of in_data at stage-0 load and carried along with the data.
  - Adds output out_perr (1 bit) = out_valid & (^out_data ^ stage[DEPTH-1].parity).
  - out_perr resets to 0.
- When undefined: no parity field and no out_perr port. Behaviour is otherwise identical.

Decomposition:
- Package struct_pipe_pkg:
  - default constants STRUCT_PIPE_DEF_WIDTH=8 and STRUCT_PIPE_DEF_DEPTH=2;
  - function calc_parity.
- Stage struct typedef: local to the module, because it depends on WIDTH.
- One sub-module, struct_pipe_stage: a single struct register with vld/adv handling, instantiated DEPTH times via generate. The top holds the ready chain and the occupancy counter.

Test Plan:
- Reset then stream 0x11,0x22,0x33 with out_ready=1 → out_data 0x11,0x22,0x33 on cycles 2,3,4 after first accept; occupancy peaks at 2; in_ready stays 1.
- Fill with 0xA0,0xA1 and out_ready=0 → in_ready=0, occupancy=2, out_data=0xA0 held stable; raise out_ready → 0xA0 then 0xA1 delivered, no loss or duplicate.
- Full, out_ready=1, in_valid=1 continuously for 8 cycles → 8 words in, 8 out, occupancy constant at 2.
- Flush with occupancy=2 and in_valid=1 → next cycle occupancy=0, out_valid=0, input not accepted; word accepted on the following cycle appears DEPTH cycles later.
- Assert reset asynchronously mid-stream (between edges) → out_valid and occupancy go 0 immediately, out_data=0; DEPTH=1 and DEPTH=4 regressions repeat the first two scenarios.
- STRUCT_PIPE_PARITY_EN: send 0x07 → out_perr=0; force a bit flip in stage 1 data → out_perr=1 while the word is on the output.
